// File: rtl/serial_collect5_pkg.sv
// Shared constants for the serial collector and the downstream 5-bit OR stage.
package serial_collect5_pkg;

    localparam int W_DEFAULT = 5;
    localparam int CNT_W     = $clog2(W_DEFAULT);

endpackage

// File: rtl/serial_collect5_hold_reg.sv
// One-entry valid/ready holding register: a load fills it; a downstream take empties it unless reloaded.
module serial_collect5_hold_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    // NOTE: the data register is reset too, so a discarded word reads back as zero rather than stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/serial_collect5.sv
// Serial-to-parallel collector: packs W accepted bits into a word and offers it over valid/ready.
module serial_collect5
    import serial_collect5_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sin_bit,
    input  logic          sin_valid,
    output logic          sin_ready,
    output logic [W-1:0]  data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] bit_cnt
);

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_bit_cnt;
    logic [W-1:0]  w_word;
    logic          w_last;
    logic          w_acc_in;
    logic          w_complete;

    assign w_last     = (r_bit_cnt == LAST);
    // Stall only when this bit would finish a word while the output register is full and not draining.
    assign sin_ready  = ~(w_last & out_valid & ~out_ready);
    assign w_acc_in   = sin_valid & sin_ready;
    assign w_complete = w_acc_in & w_last;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        w_word = r_shreg;
        if (MSB_FIRST) begin
            w_word = {r_shreg[W-2:0], sin_bit};
        end else begin
            w_word[W-1] = sin_bit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_acc_in) begin
            if (w_last) begin
                r_shreg <= '0;
            end else if (MSB_FIRST) begin
                r_shreg <= {r_shreg[W-2:0], sin_bit};
            end else begin
                r_shreg[r_bit_cnt] <= sin_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (w_acc_in) begin
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
    end

    serial_collect5_hold_reg #(
        .W (W)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_complete),
        .i_data  (w_word),
        .i_ready (out_ready),
        .o_data  (data_out),
        .o_valid (out_valid)
    );

    assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_serial_collect5.sv
// Directed self-checking bench for serial_collect5 (W=5, MSB first).
module tb_serial_collect5;
    import serial_collect5_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             sin_bit;
    logic             sin_valid;
    logic             sin_ready;
    logic [4:0]       data_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    serial_collect5 #(
        .W         (5),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_bit   (sin_bit),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit for exactly one clock edge.
    task automatic send(input logic b);
        sin_bit   = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [4:0] w);
        for (int i = 4; i >= 0; i--) send(w[i]);
    endtask

    initial begin
        rst_n     = 1'b0;
        sin_bit   = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_bit_cnt",   bit_cnt,   0);
        check("rst_data_out",  data_out,  0);
        check("rst_sin_ready", sin_ready, 1);
        tick();

        // Basic word 01010
        out_ready = 1'b1;
        send(0); send(1); send(0);
        check("basic_cnt3", bit_cnt, 3);
        send(1); send(0);
        check("basic_data",  data_out,  5'b01010);
        check("basic_valid", out_valid, 1);
        check("basic_or",    |data_out, 1);
        check("basic_cnt0",  bit_cnt,   0);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_hold",  data_out,  5'b01010);

        // All-zero word is still delivered
        send_word(5'b00000);
        check("zero_data",  data_out,  5'b00000);
        check("zero_valid", out_valid, 1);
        check("zero_or",    |data_out, 0);
        tick();
        check("zero_drain", out_valid, 0);

        // Backpressure: hold 11100 while the next word's first four bits arrive
        send_word(5'b11100);
        check("bp_word1", data_out, 5'b11100);
        out_ready = 1'b0;
        send(0); send(1); send(1); send(0);
        check("bp_cnt4",   bit_cnt,   4);
        check("bp_hold",   data_out,  5'b11100);
        check("bp_valid",  out_valid, 1);
        sin_bit   = 1'b1;
        sin_valid = 1'b1;
        #1;
        check("bp_stall_ready", sin_ready, 0);
        tick();
        check("bp_stall_data", data_out, 5'b11100);
        check("bp_stall_cnt",  bit_cnt,  4);

        // Release: completion and drain coincide, word 2 replaces word 1 directly
        out_ready = 1'b1;
        #1;
        check("sim_ready", sin_ready, 1);
        tick();
        sin_valid = 1'b0;
        check("sim_data",  data_out,  5'b01101);
        check("sim_valid", out_valid, 1);
        check("sim_cnt0",  bit_cnt,   0);
        tick();
        check("sim_drain", out_valid, 0);

        // Gaps freeze the partial word; a mid-word reset discards it
        send(1);
        tick();
        check("gap_cnt1", bit_cnt, 1);
        send(1);
        tick();
        send(0);
        check("gap_cnt3",   bit_cnt,   3);
        check("gap_nodata", out_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cnt",   bit_cnt,   0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data",  data_out,  0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_cnt",   bit_cnt,   0);

        // Fresh word after reset, held under backpressure, then reset while pending
        out_ready = 1'b0;
        send_word(5'b10000);
        check("after_data",  data_out,  5'b10000);
        check("after_valid", out_valid, 1);
        check("after_or",    |data_out, 1);
        tick();
        check("after_hold", data_out, 5'b10000);
        #2 rst_n = 1'b0;
        #1;
        check("stallrst_valid", out_valid, 0);
        check("stallrst_data",  data_out,  0);
        #2 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
